// File: rtl/prg_ray_inbox_pkg.sv
// Shared ray types and frame constants for the primary-ray path.
// Used by prg_ray_inbox and ray_fifo.
package prg_ray_inbox_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int NUM_RAYS = SCREEN_W * SCREEN_H;
    localparam int RAY_ID_W = 19;

    typedef logic [31:0] float_t;

    typedef struct packed {
        float_t x;
        float_t y;
        float_t z;
    } vector_t;

    typedef struct packed {
        vector_t               origin;
        vector_t               dir;
        logic [RAY_ID_W-1:0]   rayID;
    } ray_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DRAIN
    } inbox_state_e;

    function automatic logic [RAY_ID_W-1:0] next_id(
        input logic [RAY_ID_W-1:0] id
    );
        return id + RAY_ID_W'(1);
    endfunction

endpackage

// File: rtl/prg_ray_inbox_fifo.sv
// ray_fifo: power-of-two depth synchronous ray FIFO.
// Head is zero whenever the FIFO is empty.
module ray_fifo
    import prg_ray_inbox_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  ray_t                   wdata,
    output ray_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;
    ray_t          mem_q [DEPTH];

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/prg_ray_inbox.sv
// Ray inbox: buffers generator rays, early stall, frame tracking.
// Define PRG_RAY_ID_CHECK_EN to enable the rayID sequence checker.
module prg_ray_inbox
    import prg_ray_inbox_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int STALL_SLACK = 4,
    parameter int NUM_RAYS    = prg_ray_inbox_pkg::NUM_RAYS
) (
    input  logic clk,
    input  logic rst,
    input  logic rayReady,
    input  ray_t prg_data,
    input  logic done,
    output logic int_to_prg_stall,
    output logic ray_valid,
    output ray_t ray_data,
    input  logic ray_rdy,
    output logic frame_done,
    output logic overflow,
    output logic id_error
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THRESH = CW'(DEPTH - STALL_SLACK);
    localparam logic [RAY_ID_W-1:0] FRAME_RAYS = RAY_ID_W'(NUM_RAYS);

    logic          full, empty;
    logic [CW-1:0] occ, occ_d;
    logic          push, pop;

    logic                stall_q, stall_d;
    logic                ovf_q, ovf_d;
    logic                fd_q, fd_d;
    logic                to_idle;
    inbox_state_e        state_q, state_d;
    logic [RAY_ID_W-1:0] acc_q, acc_d;

    assign pop       = !empty && ray_rdy;
    assign push      = rayReady && (!full || pop);
    assign ray_valid = !empty;

    ray_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (prg_data),
        .rdata (ray_data),
        .full  (full),
        .empty (empty),
        .count (occ)
    );

    always_comb begin
        unique case ({push, pop})
            2'b10:   occ_d = occ + CW'(1);
            2'b01:   occ_d = occ - CW'(1);
            default: occ_d = occ;
        endcase
        stall_d = (occ_d >= THRESH);
        ovf_d   = ovf_q || (rayReady && !push);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = push ? acc_q + RAY_ID_W'(1) : acc_q;
        fd_d    = 1'b0;
        to_idle = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (push) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (done || acc_d >= FRAME_RAYS) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Late rays keep the frame open until they drain too.
                if (occ_d == '0) begin
                    state_d = ST_IDLE;
                    fd_d    = 1'b1;
                    to_idle = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                to_idle = 1'b1;
            end
        endcase
        if (to_idle) acc_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
            fd_q    <= 1'b0;
            state_q <= ST_IDLE;
            acc_q   <= '0;
        end else begin
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
            fd_q    <= fd_d;
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    assign int_to_prg_stall = stall_q;
    assign overflow         = ovf_q;
    assign frame_done       = fd_q;

`ifdef PRG_RAY_ID_CHECK_EN
    logic [RAY_ID_W-1:0] exp_q, exp_d;
    logic                id_err_q, id_err_d;

    always_comb begin
        exp_d    = exp_q;
        id_err_d = id_err_q;
        // Dropped rays still advance the expected ID.
        if (rayReady) exp_d = next_id(prg_data.rayID);
        if (push && prg_data.rayID != exp_q) id_err_d = 1'b1;
        if (to_idle) exp_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q    <= '0;
            id_err_q <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            id_err_q <= id_err_d;
        end
    end

    assign id_error = id_err_q;
`else
    assign id_error = 1'b0;
`endif

endmodule

// File: doc/prg_ray_inbox.md
# prg_ray_inbox

Receiving end of the primary-ray-generator output interface, sitting at the input of the intersection unit. Accepts `rayReady`/`prg_data` ray beats, buffers them in a small FIFO, and drives the `int_to_prg_stall` back-pressure early enough to absorb rays already in flight. It presents rays downstream on a valid/ready port and tracks frame completion.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 8.
- `STALL_SLACK`, 4: free entries reserved for rays already in flight when stall asserts.
- `NUM_RAYS`, 307200: rays per frame.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `rayReady` in 1: ray beat valid from generator, single-cycle pulse per ray.
- `prg_data` in `ray_t`: origin, dir, rayID (19 b).
- `done` in 1: generator frame-complete pulse.
- `int_to_prg_stall` out 1: registered back-pressure to generator.
- `ray_valid` out 1: head-of-FIFO ray available.
- `ray_data` out `ray_t`: head-of-FIFO ray.
- `ray_rdy` in 1: downstream accepts head when `ray_valid`.
- `frame_done` out 1: one-cycle pulse, frame fully delivered.
- `overflow` out 1: sticky; a ray arrived with no room.
- `id_error` out 1: sticky; rayID out of sequence (only with `PRG_RAY_ID_CHECK_EN`).

## Operation
- Push when `rayReady` and (not full or pop in the same cycle). Pop when `ray_valid && ray_rdy`.
- Full FIFO, `rayReady`, no pop: ray dropped, `overflow` set until reset. Occupancy unchanged.
- Occupancy counter width `$clog2(DEPTH)+1`; read/write pointers wrap modulo `DEPTH`.
- Stall: `int_to_prg_stall` next = (occupancy_next ≥ `DEPTH-STALL_SLACK`). Deasserts once occupancy_next falls below threshold; no hysteresis.
- Accepted-ray counter (19 b) increments per push; cleared on entering IDLE.
- FSM:
  - IDLE: first push → RECV (the push itself is performed).
  - RECV: `done` or accepted count reaching `NUM_RAYS` → DRAIN.
  - DRAIN: further `rayReady` still pushed (no discard); FIFO empty → pulse `frame_done`, → IDLE.
  - `done` in IDLE ignored.
- Reset (any time, including mid-frame): pointers, occupancy, counter cleared; state IDLE; FIFO contents invalid; no `frame_done` emitted.

## Timing
- Reset values: `int_to_prg_stall`=0, `ray_valid`=0, `ray_data`=0, `frame_done`=0, `overflow`=0, `id_error`=0.
- Push at edge N → `ray_valid` high after edge N+1 at earliest; no combinational in→out bypass.
- Pop takes effect at the edge where `ray_valid && ray_rdy`; next entry visible immediately after that edge if present (back-to-back pops every cycle).
- Stall registered: visible one cycle after the push crossing threshold; `STALL_SLACK` covers this cycle plus generator pipeline depth.
- `frame_done` asserted the cycle after the final pop in DRAIN.
- Simultaneous push and pop: occupancy unchanged; legal at full and empty (empty: pop impossible since `ray_valid`=0, push proceeds).

## Configuration
- `PRG_RAY_ID_CHECK_EN` defined: expected-ID register (19 b, reset 0) compared with `prg_data.rayID` on every push; mismatch sets sticky `id_error`; expected = received ID + 1; cleared on IDLE entry. Dropped rays also advance the expectation.
- Undefined: checker and register absent, `id_error` tied 0.

## Structure
- Shared package: `ray_t`, `vector_t`, `float_t`, `NUM_RAYS`, screen-size constants; `ray_t` is not redefined here.
- Sub-module `ray_fifo`: parameterised-depth synchronous FIFO (data, push, pop, full, empty, occupancy). Stall logic, FSM, counters, checker live in `prg_ray_inbox`.

## Test plan
- Reset, 3 rays IDs 0,1,2 with `ray_rdy`=1 → each on `ray_data` one cycle after push, in order; `int_to_prg_stall` stays 0.
- `ray_rdy`=0, 12 pushes (DEPTH 16, SLACK 4) → stall high after the 12th push edge; pushes 13–16 accepted; 17th sets `overflow`, ray dropped.
- Full FIFO, push and pop same cycle → occupancy stays 16, no overflow, new ray queued last.
- 5 rays, then `done`, `ray_rdy` held low 10 cycles then high → 5 pops, `frame_done` one pulse after 5th pop; FSM back to IDLE.
- With `PRG_RAY_ID_CHECK_EN`: IDs 0,1,3 → `id_error` set at third push, stays set; without the macro, `id_error`=0.
- `rst` low mid-frame with 6 entries → all outputs 0 immediately; next push restarts at occupancy 1, no `frame_done`.
